// File: rtl/shblk_collect_pkg.sv
// -----------------------------------------------------------------------------
// shblk_collect_pkg
// Shared masking-width constants and helpers for the share collection stage.
//   SHBLK_D_DEFAULT     : default number of shares per sharing
//   SHBLK_WIDTH_DEFAULT : default bits per share
//   idx_width(n)        : bits needed to count 0..n-1, never less than 1
// -----------------------------------------------------------------------------
package shblk_collect_pkg;

    localparam int SHBLK_D_DEFAULT     = 2;
    localparam int SHBLK_WIDTH_DEFAULT = 8;

    // A single-share configuration still needs a 1-bit counter so the
    // share index signal has a legal, non-zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shblk_collect.sv
// -----------------------------------------------------------------------------
// shblk_collect
// Collects d shares, one per input beat, into a block-based sharing and
// presents the complete sharing downstream. An assembly buffer holds shares
// 0..d-2 while the output register holds the previous frame, so a new frame
// can be gathered while the old one waits; one frame per d cycles sustained.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   i_in_share   : one share, index implied by arrival order
//   i_in_valid   : input beat valid
//   i_in_last    : source marks this beat as share d-1
//   o_in_ready   : stage accepts a beat this cycle
//   o_shblk      : assembled sharing, share j at [width*j +: width]
//   o_out_valid  : o_shblk holds a complete frame
//   i_out_ready  : downstream accepts the frame
//   o_err        : sticky framing-error flag
// -----------------------------------------------------------------------------
module shblk_collect
    import shblk_collect_pkg::*;
#(
    parameter int d     = SHBLK_D_DEFAULT,
    parameter int width = SHBLK_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width-1:0]     i_in_share,
    input  logic                 i_in_valid,
    input  logic                 i_in_last,
    output logic                 o_in_ready,
    output logic [d*width-1:0]   o_shblk,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_err
);

    localparam int             IW       = idx_width(d);
    localparam logic [IW-1:0]  IDX_LAST = IW'(d - 1);

    logic [IW-1:0]       r_idx;
    logic [d*width-1:0]  r_shblk;
    logic                r_out_valid;
    logic                r_err;

    logic                w_last_pos;
    logic                w_in_xfer;
    logic                w_err_beat;
    logic                w_good_beat;
    logic                w_load;
    logic                w_drain;
    logic [d*width-1:0]  w_frame;

    assign w_last_pos  = (r_idx == IDX_LAST);
    // The final beat may only land in the output register when it is empty
    // or being drained in this same cycle.
    assign o_in_ready  = !w_last_pos || !r_out_valid || i_out_ready;
    assign w_in_xfer   = i_in_valid && o_in_ready;
    assign w_err_beat  = w_in_xfer && (i_in_last != w_last_pos);
    assign w_good_beat = w_in_xfer && !w_err_beat;
    assign w_load      = w_good_beat && w_last_pos;
    assign w_drain     = r_out_valid && i_out_ready;

    // Share counter: wraps after the final share or after a framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_in_xfer) begin
            if (w_err_beat || w_last_pos) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    // Assembly buffer for shares 0..d-2; absent when d == 1.
    generate
        if (d > 1) begin : g_asm
            logic [(d-1)*width-1:0] r_asm;
            for (genvar gi = 0; gi < d - 1; gi++) begin : g_slot
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_asm[gi*width +: width] <= '0;
                    end else if (w_good_beat && (r_idx == IW'(gi))) begin
                        r_asm[gi*width +: width] <= i_in_share;
                    end
                end
            end
            assign w_frame = {i_in_share, r_asm};
        end else begin : g_no_asm
            assign w_frame = i_in_share;
        end
    endgenerate

    // Output register: a simultaneous drain and load keeps valid high and
    // presents the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shblk     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_shblk <= w_frame;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_beat) begin
            r_err <= 1'b1;
        end
    end

    assign o_shblk     = r_shblk;
    assign o_out_valid = r_out_valid;
    assign o_err       = r_err;

endmodule

// File: tb/tb_shblk_collect.sv
// -----------------------------------------------------------------------------
// tb_shblk_collect
// Scoreboard bench: the driver feeds a share-list model and queues expected
// frames; separate monitors pop and compare whenever a frame is handed off.
// Covers d=2 (directed + random) and d=1 (directed + random).
// -----------------------------------------------------------------------------
module tb_shblk_collect;

    localparam int D = 2;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // d=2 instance
    logic [W-1:0]   in_share  = '0;
    logic           in_valid  = 1'b0;
    logic           in_last   = 1'b0;
    logic           in_ready;
    logic [D*W-1:0] shblk;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           err;

    // d=1 instance
    logic [W-1:0]   in_share1  = '0;
    logic           in_valid1  = 1'b0;
    logic           in_last1   = 1'b0;
    logic           in_ready1;
    logic [W-1:0]   shblk1;
    logic           out_valid1;
    logic           out_ready1 = 1'b0;
    logic           err1;

    shblk_collect #(.d(D), .width(W)) dut (
        .clk(clk), .rst(rst),
        .i_in_share(in_share), .i_in_valid(in_valid), .i_in_last(in_last),
        .o_in_ready(in_ready), .o_shblk(shblk), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_err(err)
    );

    shblk_collect #(.d(1), .width(W)) dut1 (
        .clk(clk), .rst(rst),
        .i_in_share(in_share1), .i_in_valid(in_valid1), .i_in_last(in_last1),
        .o_in_ready(in_ready1), .o_shblk(shblk1), .o_out_valid(out_valid1),
        .i_out_ready(out_ready1), .o_err(err1)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model, d=2 ----------------
    logic [W-1:0]   cur[$];      // shares gathered for the frame in progress
    bit             occ  = 0;    // a frame is waiting downstream
    bit             m_err = 0;
    logic [D*W-1:0] exp_q[$];

    // ---------------- reference model, d=1 ----------------
    bit             occ1  = 0;
    bit             m_err1 = 0;
    logic [W-1:0]   exp_q1[$];

    task automatic model_reset();
        cur.delete();
        exp_q.delete();
        exp_q1.delete();
        occ = 0; m_err = 0; occ1 = 0; m_err1 = 0;
    endtask

    // Called just after a rising edge: apply inputs, evaluate at the falling
    // edge, then advance to just after the next rising edge.
    task automatic cycle2(input logic v, input logic [W-1:0] s, input logic l,
                          input logic ordy, output bit acc);
        bit exp_ready;
        bit drained;
        bit loaded;
        logic [D*W-1:0] frame;
        in_valid = v; in_share = s; in_last = l; out_ready = ordy;
        @(negedge clk);
        exp_ready = (cur.size() != D - 1) || !occ || ordy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("out_valid", {31'd0, out_valid}, {31'd0, occ});
        acc     = v && exp_ready;
        drained = occ && ordy;
        loaded  = 0;
        if (acc) begin
            if (l != (cur.size() == D - 1)) begin
                m_err = 1;
                cur.delete();
            end else begin
                cur.push_back(s);
                if (cur.size() == D) begin
                    frame = '0;
                    for (int j = 0; j < D; j++) frame[j*W +: W] = cur[j];
                    exp_q.push_back(frame);
                    cur.delete();
                    loaded = 1;
                end
            end
        end
        occ = loaded || (occ && !drained);
        @(posedge clk); #1;
    endtask

    task automatic cycle1(input logic v, input logic [W-1:0] s, input logic l,
                          input logic ordy);
        bit exp_ready;
        bit drained;
        bit loaded;
        in_valid1 = v; in_share1 = s; in_last1 = l; out_ready1 = ordy;
        @(negedge clk);
        exp_ready = !occ1 || ordy;
        chk("d1_in_ready", {31'd0, in_ready1}, {31'd0, exp_ready});
        chk("d1_err", {31'd0, err1}, {31'd0, m_err1});
        chk("d1_out_valid", {31'd0, out_valid1}, {31'd0, occ1});
        drained = occ1 && ordy;
        loaded  = 0;
        if (v && exp_ready) begin
            if (!l) begin
                m_err1 = 1;
            end else begin
                exp_q1.push_back(s);
                loaded = 1;
            end
        end
        occ1 = loaded || (occ1 && !drained);
        @(posedge clk); #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL frame: got unexpected frame %0h, expected none (t=%0t)", shblk, $time);
            end else begin
                chk("frame", {16'd0, shblk}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL d1_frame: got unexpected frame %0h, expected none (t=%0t)", shblk1, $time);
            end else begin
                chk("d1_frame", {24'd0, shblk1}, {24'd0, exp_q1.pop_front()});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        logic          hv, hl;
        logic [W-1:0]  hs;

        // Reset values
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_shblk", {16'd0, shblk}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Single frame
        cycle2(1, 8'hA5, 0, 1, acc);
        cycle2(1, 8'h3C, 1, 1, acc);
        cycle2(0, 8'h00, 0, 1, acc);

        // Back-to-back frames
        for (int f = 0; f < 4; f++) begin
            cycle2(1, 8'(8'h10 + 2*f), 0, 1, acc);
            cycle2(1, 8'(8'h11 + 2*f), 1, 1, acc);
        end
        cycle2(0, 8'h00, 0, 1, acc);

        // Backpressure: frame 1 waits, frame 2 collects and stalls on last share
        cycle2(1, 8'hB0, 0, 0, acc);
        cycle2(1, 8'hB1, 1, 0, acc);
        cycle2(1, 8'hC0, 0, 0, acc);
        cycle2(1, 8'hC1, 1, 0, acc);
        cycle2(1, 8'hC1, 1, 0, acc);
        cycle2(1, 8'hC1, 1, 1, acc);
        cycle2(0, 8'h00, 0, 1, acc);

        // Framing error on share 0, then a good frame
        cycle2(1, 8'h99, 1, 1, acc);
        cycle2(1, 8'h11, 0, 1, acc);
        cycle2(1, 8'h22, 1, 1, acc);
        cycle2(0, 8'h00, 0, 1, acc);

        // Reset mid-frame, pulsed away from any clock edge
        cycle2(1, 8'h77, 0, 1, acc);
        in_valid = 0;
        #1 rst = 1'b1;
        #1;
        chk("amid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("amid_shblk", {16'd0, shblk}, 32'd0);
        chk("amid_err", {31'd0, err}, 32'd0);
        chk("amid_in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        cycle2(1, 8'h01, 0, 1, acc);
        cycle2(1, 8'h02, 1, 1, acc);
        cycle2(0, 8'h00, 0, 1, acc);

        // Random traffic with backpressure and occasional framing errors
        hv = 0; hs = '0; hl = 0; acc = 1;
        for (int n = 0; n < 1500; n++) begin
            if (!(hv && !acc)) begin
                hv = ($urandom_range(0, 3) != 0);
                hs = 8'($urandom);
                hl = (cur.size() == D - 1);
                if ($urandom_range(0, 19) == 0) hl = !hl;
            end
            cycle2(hv, hs, hl, logic'($urandom_range(0, 9) < 7), acc);
        end
        for (int n = 0; n < 4; n++) cycle2(0, 8'h00, 0, 1, acc);
        chk("drain_q", exp_q.size(), 32'd0);

        // d=1: every beat is a whole frame
        cycle1(1, 8'h5A, 1, 1);
        cycle1(1, 8'hC3, 1, 1);
        cycle1(0, 8'h00, 0, 1);
        cycle1(0, 8'h00, 0, 1);
        for (int n = 0; n < 300; n++) begin
            cycle1(logic'($urandom_range(0, 3) != 0), 8'($urandom),
                   logic'($urandom_range(0, 19) != 0),
                   logic'($urandom_range(0, 9) < 7));
        end
        for (int n = 0; n < 3; n++) cycle1(0, 8'h00, 0, 1);
        chk("d1_drain_q", exp_q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shblk_collect.md
# shblk_collect

Upstream collection stage for masked data. It accepts one share per beat over a valid/ready handshake and assembles `d` shares into a block-based sharing register. It then presents the complete sharing downstream with its own valid/ready handshake; the block-to-bit sharing conversion stage consumes this output. An assembly buffer and an output register allow the next frame to be collected while the previous one waits, sustaining one frame per `d` cycles.

## Interface
- `d`, 2, number of shares per sharing; must be ≥1.
- `width`, 8, bits per share.

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset; asynchronous and active-high.
- `in_share`  input  `width`  one share; share index is implied by arrival order (0 first).
- `in_valid`  input  1  `in_share` / `in_last` valid.
- `in_last`  input  1  marks the beat the source declares as share `d-1`.
- `in_ready`  output  1  stage can accept a beat this cycle.
- `shblk`  output  `d*width`  assembled sharing, share `j` at bits `[width*j +: width]`.
- `out_valid`  output  1  `shblk` holds a complete frame.
- `out_ready`  input  1  downstream accepts the frame.
- `err`  output  1  sticky framing-error flag.

## Operation
- **Transfers.**
  - An input transfer happens when `in_valid && in_ready`.
  - An output transfer happens when `out_valid && out_ready`.
- **Share counter.**
  - `idx` counts 0..`d-1` and increments on each input transfer.
  - It wraps to 0 after a transfer at `d-1`, or after a framing error.
- **Assembly buffer.**
  - Width is `(d-1)*width`.
  - A transfer at `idx=j<d-1` writes slot `j`.
- **Final beat** (`idx=d-1`): the output register loads `{in_share, assembly}` and `out_valid` is set.
- **Ready rule.**
  - When `idx != d-1`: `in_ready = 1`.
  - When `idx == d-1`: `in_ready = !out_valid || out_ready`.
  - The final beat may therefore overwrite an output frame only in the same cycle that frame drains.
- **out_valid update.**
  - Set on a final-beat transfer.
  - Cleared on an output transfer that has no simultaneous final-beat load.
  - A simultaneous drain and load keeps it at 1 and presents the new data.
- **Framing check**, evaluated on each input transfer:
  - An error is `in_last != (idx==d-1)`.
  - On error, `err` is set and remains 1 until reset.
  - `idx` returns to 0.
  - The beat is discarded; the output register is not loaded.
  - The assembly buffer contents are don't-care.
- **Case d=1.** There is no assembly buffer. Every beat is final, and `in_last` must be 1.
- **Data handling.** The block never combines shares; they are only routed to their slots.

## Timing
- **Latency.** `out_valid` rises the cycle after the final-beat transfer. `shblk` is registered.
- **Throughput.** With `out_ready` held at 1, one frame per `d` cycles and no bubbles.
- **Output hold.** While `out_valid=1 && !out_ready`, `shblk` and `out_valid` are stable.
- **Input backpressure.** The source must hold `in_share` / `in_last` while `in_valid && !in_ready`.
- **Reset values.** `idx=0`, assembly buffer `=0`, `shblk=0`, `out_valid=0`, `err=0`. `in_ready` is therefore 1 during and after reset.
- **Reset mid-frame.** Partial shares are discarded and the next accepted beat is share 0.
- **Simultaneous events.**
  - A framing error on a beat at `idx=d-1` while `out_valid=1 && out_ready=1`: the old frame drains, `out_valid` becomes 0, and nothing is loaded.
- **Paths.** No combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready` only when `idx=d-1`.

## Structure
- The counter width is `$clog2(d)` with a minimum of 1. Place this width helper in the shared package alongside the other masking-width constants; no typedefs are needed.
- The block is single-level: counter, assembly buffer, output register and control live in one module, with no sub-module.
- The output slot layout must match the block-based sharing convention used by the downstream conversion stage.

## Test plan
- **Single frame** (`d=2`, `width=8`): send `0xA5`, then `0x3C` with `in_last` on the second beat → one cycle later `out_valid=1`, `shblk=0x3CA5`, `err=0`.
- **Back-to-back:** 4 frames, `out_ready=1`, `in_valid` held high → `out_valid` pulses every 2 cycles with the correct data and no `in_ready` deassertion.
- **Backpressure:** `out_ready=0` after frame 1 → share 0 of frame 2 is accepted; `in_ready=0` at `idx=1`; `out_ready=1` → frame 1 drains and frame 2 loads in the same cycle, `out_valid` stays 1.
- **Framing error:** `in_last=1` on share 0 → `err=1` sticky, no `out_valid`; the next 2-beat frame `0x11`, `0x22` outputs `0x2211`.
- **Reset mid-frame:** accept `0x77`, pulse `rst` asynchronously → all outputs 0; the next frame `0x01`, `0x02` outputs `0x0201`.
- **d=1** (`width=8`): beats `0x5A`, `0xC3` with `in_last=1` → `shblk` shows `0x5A`, then `0xC3`, on consecutive cycles.
